// File: rtl/opm_write_sequencer.sv
// Queues host register writes and replays each one on the IKAOPM CPU bus as an
// address cycle followed by a data cycle, with programmable setup/strobe/hold/recovery widths.
module opm_write_sequencer #(
  parameter int DEPTH       = 8,
  parameter int SETUP_CYC   = 15,
  parameter int STROBE_CYC  = 20,
  parameter int HOLD_CYC    = 15,
  parameter int RECOVER_CYC = 256
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     i_WR_VALID,
  output logic                     o_WR_READY,
  input  logic [7:0]               i_WR_ADDR,
  input  logic [7:0]               i_WR_DATA,
  input  logic                     i_PAUSE,
  output logic                     o_CS_n,
  output logic                     o_WR_n,
  output logic                     o_A0,
  output logic [7:0]               o_D,
  output logic [$clog2(DEPTH):0]   o_LEVEL,
  output logic                     o_BUSY
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_HR  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int MAX_CYC = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] C_SETUP   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_STROBE  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] C_HOLD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_RECOVER = CW'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    RECOVER
  } state_t;

  state_t          state, state_next, bus_state;
  logic [CW-1:0]   cnt, cnt_next;
  logic            push, pop;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      cur_addr, cur_data;
  logic            cs_next, wr_next, a0_next;
  logic [7:0]      d_next;

  assign o_WR_READY = ~i_RST & (o_LEVEL != LW'(DEPTH));
  assign push       = i_WR_VALID & o_WR_READY;

  always_ff @(posedge i_EMUCLK) begin
    if (push) begin
      mem[wr_ptr] <= {i_WR_ADDR, i_WR_DATA};
    end
  end

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_LEVEL <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_LEVEL <= o_LEVEL + 1'b1;
        2'b01:   o_LEVEL <= o_LEVEL - 1'b1;
        default: o_LEVEL <= o_LEVEL;
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      cur_data <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (pop) {cur_addr, cur_data} <= mem[rd_ptr];
    end
  end

  // The phase counter is loaded with N-1 on entry; the phase ends when it hits zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    if (state == IDLE) begin
      if ((o_LEVEL != '0) && !i_PAUSE) begin
        pop        = 1'b1;
        state_next = A_SETUP;
        cnt_next   = C_SETUP;
      end
    end else if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
    end else begin
      case (state)
        A_SETUP:  begin state_next = A_STROBE; cnt_next = C_STROBE;  end
        A_STROBE: begin state_next = A_HOLD;   cnt_next = C_HOLD;    end
        A_HOLD:   begin state_next = D_SETUP;  cnt_next = C_SETUP;   end
        D_SETUP:  begin state_next = D_STROBE; cnt_next = C_STROBE;  end
        D_STROBE: begin state_next = D_HOLD;   cnt_next = C_HOLD;    end
        D_HOLD:   begin state_next = RECOVER;  cnt_next = C_RECOVER; end
        default:  begin state_next = IDLE;     cnt_next = '0;        end
      endcase
    end
  end

  always_comb begin
    cs_next = 1'b1;
    wr_next = 1'b1;
    a0_next = o_A0;
    d_next  = o_D;
    case (state)
      A_SETUP:  begin cs_next = 1'b0; a0_next = 1'b0; d_next = cur_addr; end
      A_STROBE: begin cs_next = 1'b0; wr_next = 1'b0; a0_next = 1'b0; d_next = cur_addr; end
      A_HOLD:   begin a0_next = 1'b0; d_next = cur_addr; end
      D_SETUP:  begin cs_next = 1'b0; a0_next = 1'b1; d_next = cur_data; end
      D_STROBE: begin cs_next = 1'b0; wr_next = 1'b0; a0_next = 1'b1; d_next = cur_data; end
      D_HOLD:   begin a0_next = 1'b1; d_next = cur_data; end
      RECOVER:  begin a0_next = 1'b1; d_next = cur_data; end
      default:  ;
    endcase
  end

  // Busy also tracks the phase still visible on the registered bus, so it never
  // drops while the pins reflect an unfinished transaction.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      o_CS_n    <= 1'b1;
      o_WR_n    <= 1'b1;
      o_A0      <= 1'b0;
      o_D       <= '0;
      bus_state <= IDLE;
      o_BUSY    <= 1'b0;
    end else begin
      o_CS_n    <= cs_next;
      o_WR_n    <= wr_next;
      o_A0      <= a0_next;
      o_D       <= d_next;
      bus_state <= state;
      o_BUSY    <= (state != IDLE) | (bus_state != IDLE) | (o_LEVEL != '0);
    end
  end

endmodule

// File: tb/tb_opm_write_sequencer.sv
// Self-checking bench for opm_write_sequencer: transaction-level FIFO/timing model
// plus a bus monitor that decodes OPM writes and checks strobe protocol.
module tb_opm_write_sequencer;

  localparam int DEPTH     = 8;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int SETUP     = 15;
  localparam int STROBE    = 20;
  localparam int HOLD      = 15;
  localparam int RECOVER   = 256;
  localparam int WRITE_CYC = 2 * (SETUP + STROBE + HOLD) + RECOVER;

  logic          i_EMUCLK = 1'b0;
  logic          i_RST = 1'b1;
  logic          i_WR_VALID = 1'b0;
  logic [7:0]    i_WR_ADDR = '0;
  logic [7:0]    i_WR_DATA = '0;
  logic          i_PAUSE = 1'b0;
  logic          o_WR_READY, o_CS_n, o_WR_n, o_A0, o_BUSY;
  logic [7:0]    o_D;
  logic [LW-1:0] o_LEVEL;

  opm_write_sequencer #(
    .DEPTH(DEPTH), .SETUP_CYC(SETUP), .STROBE_CYC(STROBE),
    .HOLD_CYC(HOLD), .RECOVER_CYC(RECOVER)
  ) dut (
    .i_EMUCLK(i_EMUCLK), .i_RST(i_RST), .i_WR_VALID(i_WR_VALID),
    .o_WR_READY(o_WR_READY), .i_WR_ADDR(i_WR_ADDR), .i_WR_DATA(i_WR_DATA),
    .i_PAUSE(i_PAUSE), .o_CS_n(o_CS_n), .o_WR_n(o_WR_n), .o_A0(o_A0),
    .o_D(o_D), .o_LEVEL(o_LEVEL), .o_BUSY(o_BUSY)
  );

  always #5 i_EMUCLK = ~i_EMUCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rst_q = 1'b1;

  // Reference model: FIFO contents, cycles left in the current write,
  // writes expected on the bus, and expected address-phase CS_n fall edges.
  logic [15:0] fifo_m [$];
  logic [15:0] exp_q [$];
  int          exp_fall [$];
  int          rem = 0;

  always @(posedge i_EMUCLK) begin
    cyc   <= cyc + 1;
    rst_q <= i_RST;
  end

  // Bus monitor
  logic       prev_cs = 1'b1, prev_wr = 1'b1, have_addr = 1'b0, stable = 1'b1;
  logic       st_a0 = 1'b0;
  logic [7:0] st_d = '0, pend_addr = '0;
  int         cs_fall_cyc = 0, wr_fall_cyc = 0, wr_rise_cyc = 0;

  always @(negedge i_EMUCLK) begin
    if (rst_q) begin
      prev_cs = 1'b1; prev_wr = 1'b1; have_addr = 1'b0;
    end else begin
      if (!o_WR_n && o_CS_n) begin
        n_vec++; n_err++;
        $display("[TB] FAIL strobe_without_cs at cycle %0d: WR_n=0 while CS_n=1", cyc);
      end
      if (prev_cs && !o_CS_n) begin
        cs_fall_cyc = cyc;
        n_vec++;
        if (!o_A0) begin
          if (exp_fall.size() == 0) begin
            n_err++;
            $display("[TB] FAIL unexpected_cs_fall at cycle %0d, none expected", cyc);
          end else begin
            int ef;
            ef = exp_fall.pop_front();
            if (cyc != ef) begin
              n_err++;
              $display("[TB] FAIL cs_fall_time got cycle %0d expected %0d", cyc, ef);
            end
          end
        end else if (cyc - wr_rise_cyc != HOLD) begin
          n_err++;
          $display("[TB] FAIL hold_width got %0d expected %0d", cyc - wr_rise_cyc, HOLD);
        end
      end
      if (prev_wr && !o_WR_n) begin
        n_vec++;
        if (cyc - cs_fall_cyc != SETUP) begin
          n_err++;
          $display("[TB] FAIL setup_width got %0d expected %0d", cyc - cs_fall_cyc, SETUP);
        end
        st_a0 = o_A0; st_d = o_D; wr_fall_cyc = cyc; stable = 1'b1;
      end else if (!o_WR_n) begin
        if (o_A0 !== st_a0 || o_D !== st_d) stable = 1'b0;
      end
      if (!prev_wr && o_WR_n) begin
        n_vec++;
        if (!stable || o_A0 !== st_a0 || o_D !== st_d) begin
          n_err++;
          $display("[TB] FAIL bus_stability A0/D changed during strobe: now A0=%b D=%h, at fall A0=%b D=%h",
                   o_A0, o_D, st_a0, st_d);
        end
        n_vec++;
        if (cyc - wr_fall_cyc != STROBE) begin
          n_err++;
          $display("[TB] FAIL strobe_width got %0d expected %0d", cyc - wr_fall_cyc, STROBE);
        end
        wr_rise_cyc = cyc;
        if (!st_a0) begin
          pend_addr = st_d; have_addr = 1'b1;
        end else begin
          n_vec++;
          if (!have_addr || exp_q.size() == 0) begin
            n_err++;
            $display("[TB] FAIL write_pair got data %h with no pending address/expected write (have_addr=%b, queued=%0d)",
                     st_d, have_addr, exp_q.size());
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({pend_addr, st_d} !== e) begin
              n_err++;
              $display("[TB] FAIL write_pair got %h expected %h", {pend_addr, st_d}, e);
            end
          end
          have_addr = 1'b0;
        end
      end
      prev_cs = o_CS_n; prev_wr = o_WR_n;
    end
  end

  // One clock of stimulus plus model update; checks level/ready afterwards.
  task automatic tick(input logic valid, input logic [7:0] a, input logic [7:0] d,
                      input logic pause, input logic rst);
    logic push_ok, pop_ok;
    int   edge_now;
    i_WR_VALID = valid; i_WR_ADDR = a; i_WR_DATA = d; i_PAUSE = pause; i_RST = rst;
    push_ok  = !rst && valid && (fifo_m.size() != DEPTH);
    pop_ok   = !rst && (rem == 0) && (fifo_m.size() != 0) && !pause;
    edge_now = cyc + 1;
    @(posedge i_EMUCLK);
    if (rst) begin
      if (rem != 0 && exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
      fifo_m.delete(); exp_fall.delete(); rem = 0;
    end else begin
      if (rem != 0) rem--;
      else if (pop_ok) begin
        exp_q.push_back(fifo_m.pop_front());
        exp_fall.push_back(edge_now + 1);
        rem = WRITE_CYC;
      end
      if (push_ok) fifo_m.push_back({a, d});
    end
    @(negedge i_EMUCLK);
    n_vec++;
    if (o_LEVEL !== LW'(fifo_m.size())) begin
      n_err++;
      $display("[TB] FAIL level got %0d expected %0d", o_LEVEL, fifo_m.size());
    end
    n_vec++;
    if (o_WR_READY !== (!rst && fifo_m.size() != DEPTH)) begin
      n_err++;
      $display("[TB] FAIL wr_ready got %b expected %b", o_WR_READY, (!rst && fifo_m.size() != DEPTH));
    end
  endtask

  task automatic idle_ticks(input int n, input logic pause);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, pause, 1'b0);
  endtask

  task automatic drain(input int max_ticks);
    int k;
    k = 0;
    while ((rem != 0 || fifo_m.size() != 0) && k < max_ticks) begin
      tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      k++;
    end
    idle_ticks(3, 1'b0);
    n_vec++;
    if (exp_q.size() != 0 || exp_fall.size() != 0 || fifo_m.size() != 0) begin
      n_err++;
      $display("[TB] FAIL drain_timeout writes outstanding=%0d falls outstanding=%0d queued=%0d, required 0",
               exp_q.size(), exp_fall.size(), fifo_m.size());
    end
  endtask

  task automatic test_reset;
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_vec++;
    if ({o_CS_n, o_WR_n, o_A0, o_D, o_BUSY} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got CS_n=%b WR_n=%b A0=%b D=%h BUSY=%b expected 1 1 0 00 0",
               o_CS_n, o_WR_n, o_A0, o_D, o_BUSY);
    end
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_single_write;
    int k;
    tick(1'b1, 8'h28, 8'h42, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if (o_CS_n !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL cs_early got CS_n=%b expected 1 at E0+1", o_CS_n);
    end
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if ({o_CS_n, o_WR_n, o_A0, o_D} !== {1'b0, 1'b1, 1'b0, 8'h28}) begin
      n_err++;
      $display("[TB] FAIL first_addr_setup got CS_n=%b WR_n=%b A0=%b D=%h expected 0 1 0 28",
               o_CS_n, o_WR_n, o_A0, o_D);
    end
    k = 0;
    while (o_BUSY === 1'b1 && k < 600) begin
      tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      k++;
    end
    n_vec++;
    if (k != WRITE_CYC + 1) begin
      n_err++;
      $display("[TB] FAIL busy_drop got %0d cycles after CS_n fall expected %0d", k, WRITE_CYC + 1);
    end
    n_vec++;
    if ({o_A0, o_D} !== {1'b1, 8'h42}) begin
      n_err++;
      $display("[TB] FAIL idle_hold got A0=%b D=%h expected 1 42", o_A0, o_D);
    end
  endtask

  task automatic test_full_burst;
    for (int i = 0; i < DEPTH; i++)
      tick(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    n_vec++;
    if (o_WR_READY !== 1'b0 || o_LEVEL !== LW'(DEPTH)) begin
      n_err++;
      $display("[TB] FAIL full_state got ready=%b level=%0d expected 0 %0d", o_WR_READY, o_LEVEL, DEPTH);
    end
    tick(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
    n_vec++;
    if (o_LEVEL !== LW'(DEPTH)) begin
      n_err++;
      $display("[TB] FAIL refused_push got level %0d expected %0d", o_LEVEL, DEPTH);
    end
    tick(1'b1, 8'hBB, 8'h66, 1'b0, 1'b0);
    n_vec++;
    if (o_LEVEL !== LW'(DEPTH - 1)) begin
      n_err++;
      $display("[TB] FAIL full_push_pop got level %0d expected %0d", o_LEVEL, DEPTH - 1);
    end
    tick(1'b1, 8'hCC, 8'h77, 1'b0, 1'b0);
    n_vec++;
    if (o_LEVEL !== LW'(DEPTH)) begin
      n_err++;
      $display("[TB] FAIL push_after_pop got level %0d expected %0d", o_LEVEL, DEPTH);
    end
    drain((DEPTH + 2) * (WRITE_CYC + 2));
  endtask

  task automatic test_pause;
    for (int i = 0; i < 3; i++)
      tick(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    idle_ticks(50, 1'b1);
    n_vec++;
    if (o_LEVEL !== LW'(3) || o_CS_n !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL paused_idle got level=%0d CS_n=%b expected 3 1", o_LEVEL, o_CS_n);
    end
    idle_ticks(25, 1'b0);
    n_vec++;
    if (o_WR_n !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL in_strobe got WR_n=%b expected 0", o_WR_n);
    end
    idle_ticks(WRITE_CYC + 40, 1'b1);
    n_vec++;
    if (o_LEVEL !== LW'(2) || o_CS_n !== 1'b1 || o_BUSY !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL pause_stall got level=%0d CS_n=%b BUSY=%b expected 2 1 1", o_LEVEL, o_CS_n, o_BUSY);
    end
    drain(3 * (WRITE_CYC + 2));
  endtask

  task automatic test_reset_mid_write;
    tick(1'b1, 8'h3C, 8'hE1, 1'b0, 1'b0);
    tick(1'b1, 8'h3D, 8'hE2, 1'b0, 1'b0);
    idle_ticks(74, 1'b0);
    n_vec++;
    if ({o_WR_n, o_A0, o_D} !== {1'b0, 1'b1, 8'hE1}) begin
      n_err++;
      $display("[TB] FAIL pre_reset_strobe got WR_n=%b A0=%b D=%h expected 0 1 e1", o_WR_n, o_A0, o_D);
    end
    tick(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
    n_vec++;
    if ({o_CS_n, o_WR_n, o_A0, o_D, o_LEVEL, o_WR_READY} !== {1'b1, 1'b1, 1'b0, 8'h00, LW'(0), 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_abort got CS_n=%b WR_n=%b A0=%b D=%h level=%0d ready=%b expected 1 1 0 00 0 0",
               o_CS_n, o_WR_n, o_A0, o_D, o_LEVEL, o_WR_READY);
    end
    idle_ticks(WRITE_CYC + 20, 1'b0);
    n_vec++;
    if (o_BUSY !== 1'b0 || o_CS_n !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL post_reset_quiet got BUSY=%b CS_n=%b expected 0 1", o_BUSY, o_CS_n);
    end
    drain(10);
  endtask

  task automatic test_random;
    logic pause;
    pause = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) pause = ~pause;
      tick(($urandom_range(0, 31) == 0), 8'($urandom), 8'($urandom), pause, 1'b0);
    end
    drain((DEPTH + 2) * (WRITE_CYC + 2));
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_burst();
    test_pause();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL global_timeout simulation did not complete within 60000 cycles");
    $fatal(1, "[TB] timeout");
  end

endmodule
